// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory request issue, prefetch FIFO and redirect flush.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        fetch_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [31:0] pc, resp_pc, target;
  logic [CW-1:0] live, discard, count;
  logic [AW-1:0] rd, wr;
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic run, fire, drop, push, pop, consumed;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;
  logic [0:0] state;
  assign run = state == RUN;
  assign fetch_fault = !reset && state == FAULT;
  always_ff @(posedge clock)
    if (reset) state <= RUN;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) state <= FAULT;
`else
  assign run = 1'b1;
  assign fetch_fault = 1'b0;
`endif
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign fire = imem_req_valid && imem_req_ready;
  assign drop = imem_resp_valid && discard != '0;
  assign consumed = imem_resp_valid && (discard != '0 || live != '0);
  assign push = imem_resp_valid && discard == '0 && live != '0 && !redirect_valid;
  assign pop = instruction_valid && instruction_ready;
  assign imem_req_valid = !reset && run && !redirect_valid && (count + live < DEPTH);
  assign imem_req_addr = pc;
  assign instruction_valid = !reset && count != '0;
  assign instruction = fifo_data[rd];
  assign instruction_pc = fifo_pc[rd];
  // Live responses return in request order, so the next pushed pc is simply tracked.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      live <= '0;
      discard <= '0;
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else if (redirect_valid) begin
      pc <= target;
      resp_pc <= target;
      discard <= discard + live - CW'(consumed);
      live <= '0;
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      if (fire) pc <= pc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      live <= live + CW'(fire) - CW'(push);
      discard <= discard - CW'(drop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock)
    if (push) begin
      fifo_pc[wr] <= resp_pc;
      fifo_data[wr] <= imem_resp_data;
    end
  assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (live != '0 || discard != '0));
endmodule
